// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, sequences a registered-read instruction memory and delivers
// {instruction, pc} through a 2-entry skid buffer. Optional counters: FETCH_PERF_CNT_EN.
module fetch_sequencer #(
   parameter logic [31:0] START_ADDR = 32'h0,
   parameter logic [31:0] END_ADDR   = 32'h14,
   parameter int          MEM_BYTES  = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   output logic [31:0] imem_addr,
   output logic        imem_en,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   output logic        busy,
   output logic        done
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_flush
`endif
);

   localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, FETCH, STOP} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, tag;
   logic        inflight;
   logic [1:0]  count;
   logic [31:0] data0, data1, pc0, pc1;
   logic        redir, pop, push, issue, launch;
   logic [2:0]  load;

   // The response of the current inflight fetch lands this cycle, so it counts against
   // the buffer before a new issue is allowed.
   always_comb begin
      redir  = redirect_valid && (state != IDLE);
      launch = (state == IDLE) && start;
      pop    = (count != 2'd0) && instr_ready;
      push   = inflight && !redir;
      load   = 3'(count) - 3'(pop) + 3'(inflight);
      issue  = (state == FETCH) && !redirect_valid && (pc != END_ADDR) && (load <= 3'd1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = FETCH;
         FETCH: begin
            if (redir)
               state_nxt = FETCH;
            else if ((issue && (pc == END_ADDR - 32'd4)) || (pc == END_ADDR))
               state_nxt = STOP;
         end
         STOP: begin
            if (redir)
               state_nxt = FETCH;
            else if ((count == 2'd0) && !inflight)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      imem_en     = issue;
      imem_addr   = pc;
      busy        = (state != IDLE);
      done        = (state == STOP) && !redir && (count == 2'd0) && !inflight;
      instr_valid = (count != 2'd0);
      instr_data  = instr_valid ? data0 : 32'h0;
      instr_pc    = instr_valid ? pc0 : 32'h0;
   end

   // A redirect drops the pending response simply by never pushing it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= START_ADDR;
         tag      <= 32'h0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) tag <= pc;
         if (launch)
            pc <= START_ADDR;
         else if (redir)
            pc <= redirect_addr & ~32'h3 & ADDR_MASK;
         else if (issue)
            pc <= (pc + 32'd4) & ADDR_MASK;
      end
   end

   // Entry 0 is always the head; entry 1 only holds data when two words are buffered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 2'd0;
         data0 <= 32'h0;
         data1 <= 32'h0;
         pc0   <= 32'h0;
         pc1   <= 32'h0;
      end else if (redir) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b11: begin
               if (count == 2'd1) begin
                  data0 <= imem_rdata;
                  pc0   <= tag;
               end else begin
                  data0 <= data1;
                  pc0   <= pc1;
                  data1 <= imem_rdata;
                  pc1   <= tag;
               end
            end
            2'b10: begin
               if (count == 2'd0) begin
                  data0 <= imem_rdata;
                  pc0   <= tag;
               end else begin
                  data1 <= imem_rdata;
                  pc1   <= tag;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               data0 <= data1;
               pc0   <= pc1;
               count <= count - 2'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
      logic [32:0] s;
      s = {1'b0, a} + 33'(b);
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   // Flush events count both the buffered entries and the squashed inflight response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= 32'h0;
         perf_stall   <= 32'h0;
         perf_flush   <= 32'h0;
      end else if (launch) begin
         perf_fetched <= 32'h0;
         perf_stall   <= 32'h0;
         perf_flush   <= 32'h0;
      end else begin
         if (push)
            perf_fetched <= sat_add(perf_fetched, 2'd1);
         if ((state == FETCH) && !issue && !redirect_valid)
            perf_stall <= sat_add(perf_stall, 2'd1);
         if (redir)
            perf_flush <= sat_add(perf_flush, count + {1'b0, inflight});
      end
   end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized ready/redirect
// traffic, checked against a transaction-level model of the expected fetch stream.
module tb_fetch_sequencer;

   localparam logic [31:0] END_A = 32'h14;
   localparam logic [31:0] END_B = 32'h20;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        startA = 0, redirA = 0, readyA = 0;
   logic [31:0] redirAddrA = 0;
   logic [31:0] imemAddrA, imemRdataA, dataA, pcA;
   logic        imemEnA, validA, busyA, doneA;

   logic        startB = 0, redirB = 0, readyB = 0;
   logic [31:0] redirAddrB = 0;
   logic [31:0] imemAddrB, imemRdataB, dataB, pcB;
   logic        imemEnB, validB, busyB, doneB;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perfFetchedA, perfStallA, perfFlushA;
   logic [31:0] perfFetchedB, perfStallB, perfFlushB;
`endif

   fetch_sequencer dutA (
      .clk(clk), .rst(rst), .start(startA), .redirect_valid(redirA), .redirect_addr(redirAddrA),
      .imem_addr(imemAddrA), .imem_en(imemEnA), .imem_rdata(imemRdataA),
      .instr_valid(validA), .instr_ready(readyA), .instr_data(dataA), .instr_pc(pcA),
      .busy(busyA), .done(doneA)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perfFetchedA), .perf_stall(perfStallA), .perf_flush(perfFlushA)
`endif
   );

   fetch_sequencer #(.END_ADDR(END_B)) dutB (
      .clk(clk), .rst(rst), .start(startB), .redirect_valid(redirB), .redirect_addr(redirAddrB),
      .imem_addr(imemAddrB), .imem_en(imemEnB), .imem_rdata(imemRdataB),
      .instr_valid(validB), .instr_ready(readyB), .instr_data(dataB), .instr_pc(pcB),
      .busy(busyB), .done(doneB)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perfFetchedB), .perf_stall(perfStallB), .perf_flush(perfFlushB)
`endif
   );

   // Registered-read instruction memory shared in content by both instances.
   logic [31:0] mem [8];
   always @(posedge clk) begin
      if (imemEnA) imemRdataA <= mem[imemAddrA[4:2]];
      if (imemEnB) imemRdataB <= mem[imemAddrB[4:2]];
   end

   int checks = 0;
   int failures = 0;
   int cycle = 0;

   logic [31:0] fromA, fromB, firstDataA, firstPcA;
   int lenA, idxA, doneSeenA, firstDelA, lastDelA;
   int lenB, idxB, doneSeenB, wrapFetchB;
   logic watchB = 0;
   logic inFetchA = 0;
   int stallA = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int streamLen(input logic [31:0] from, input logic [31:0] endAddr);
      logic [31:0] p;
      int n;
      p = from;
      if (from == endAddr) return 0;
      n = 1;
      while (p != endAddr - 32'd4 && n < 8) begin
         p = (p + 32'd4) % 32;
         n++;
      end
      return n;
   endfunction

   function automatic logic [31:0] streamPc(input logic [31:0] from, input int k);
      return (from + 32'(4 * k)) % 32;
   endfunction

   function automatic logic [31:0] wordAt(input logic [31:0] addr);
      logic [31:0] a;
      a = addr;
      return mem[a[4:2]];
   endfunction

   task automatic startModelA(input logic [31:0] from);
      fromA = from; lenA = streamLen(from, END_A); idxA = 0; doneSeenA = 0;
   endtask

   task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] addr,
                                input logic rdy);
      startA = st; redirA = rd; redirAddrA = addr; readyA = rdy;
      if (rd && busyA) startModelA((addr & ~32'h3) % 32);
   endtask

   // One clock: observe both DUTs mid-cycle, then advance to just after the next edge.
   task automatic tick();
      logic [31:0] expPc;
      @(negedge clk);
      if (validA && readyA && !redirA) begin
         if (idxA < lenA) begin
            expPc = streamPc(fromA, idxA);
            checkOutput("A.pc", pcA, expPc);
            checkOutput("A.data", dataA, wordAt(expPc));
            if (idxA == 0) begin firstDataA = dataA; firstPcA = pcA; firstDelA = cycle; end
            lastDelA = cycle;
         end else
            checkOutput("A.extra", 32'(validA), 32'h0);
         idxA++;
      end
      if (doneA) begin
         checkOutput("A.doneCount", 32'(idxA), 32'(lenA));
         doneSeenA++;
      end
      if (inFetchA && !imemEnA) stallA++;
      if (imemEnA && imemAddrA == END_A - 32'd4) inFetchA = 1'b0;
      if (validB && readyB && !redirB) begin
         if (idxB < lenB) begin
            expPc = streamPc(fromB, idxB);
            checkOutput("B.pc", pcB, expPc);
            checkOutput("B.data", dataB, wordAt(expPc));
         end else
            checkOutput("B.extra", 32'(validB), 32'h0);
         idxB++;
      end
      if (doneB) doneSeenB++;
      if (watchB && imemEnB && imemAddrB == 32'h0) wrapFetchB++;
      cycle++;
      @(posedge clk);
      #1;
   endtask

   task automatic runUntilDone(input int budget);
      int n;
      n = 0;
      while (doneSeenA == 0 && n < budget) begin
         tick();
         n++;
      end
      checkOutput("A.doneReached", 32'(doneSeenA), 32'h1);
      checkOutput("A.allDelivered", 32'(idxA), 32'(lenA));
   endtask

   initial begin
      int redirCount;
      int n;
      mem[0] = 32'h01200007; mem[1] = 32'h13450000; mem[2] = 32'h36300436;
      mem[3] = 32'h78760000; mem[4] = 32'hF9830000; mem[5] = 32'hA5A50005;
      mem[6] = 32'hA5A50006; mem[7] = 32'hA5A50007;
      lenA = 0; idxA = 0; doneSeenA = 0; lenB = 0; idxB = 0; doneSeenB = 0; wrapFetchB = 0;
      fromA = 0; fromB = 0; firstDataA = 0; firstPcA = 0;

      #1 rst = 1'b1;
      #11;
      checkOutput("rst.imem_en", 32'(imemEnA), 32'h0);
      checkOutput("rst.imem_addr", imemAddrA, 32'h0);
      checkOutput("rst.instr_valid", 32'(validA), 32'h0);
      checkOutput("rst.instr_data", dataA, 32'h0);
      checkOutput("rst.instr_pc", pcA, 32'h0);
      checkOutput("rst.busy", 32'(busyA), 32'h0);
      checkOutput("rst.done", 32'(doneA), 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      tick();

      $display("[TB] streaming with instr_ready held high");
      applyStimulus(1, 0, 0, 1); startModelA(0); tick();
      applyStimulus(0, 0, 0, 1);
      runUntilDone(30);
      checkOutput("stream.firstData", firstDataA, 32'h01200007);
      checkOutput("stream.consecutive", 32'(lastDelA - firstDelA), 32'd4);
      checkOutput("stream.busyAfter", 32'(busyA), 32'h0);
      checkOutput("stream.donePulse", 32'(doneA), 32'h0);

      applyStimulus(0, 1, 32'h8, 1); tick();
      checkOutput("idleRedirect.busy", 32'(busyA), 32'h0);
      checkOutput("idleRedirect.valid", 32'(validA), 32'h0);
      applyStimulus(0, 0, 0, 1);

      $display("[TB] backpressure");
      applyStimulus(1, 0, 0, 0); startModelA(0); stallA = 0; tick();
      applyStimulus(0, 0, 0, 0); inFetchA = 1'b1;
      repeat (6) tick();
      checkOutput("bp.valid", 32'(validA), 32'h1);
      checkOutput("bp.head", dataA, 32'h01200007);
      checkOutput("bp.headPc", pcA, 32'h0);
      checkOutput("bp.imem_en", 32'(imemEnA), 32'h0);
      applyStimulus(0, 0, 0, 1);
      runUntilDone(40);
`ifdef FETCH_PERF_CNT_EN
      checkOutput("bp.perf_fetched", perfFetchedA, 32'd5);
      checkOutput("bp.perf_stall", perfStallA, 32'(stallA));
      checkOutput("bp.perf_flush", perfFlushA, 32'd0);
`endif
      inFetchA = 1'b0;

      $display("[TB] redirect with a response in flight");
      applyStimulus(1, 0, 0, 0); startModelA(0); tick();
      applyStimulus(0, 0, 0, 0);
      repeat (2) tick();
      applyStimulus(0, 1, 32'h0E, 0); tick();
      checkOutput("redir.validNext", 32'(validA), 32'h0);
      applyStimulus(0, 0, 0, 1);
      runUntilDone(30);
      checkOutput("redir.firstData", firstDataA, 32'h78760000);
      checkOutput("redir.firstPc", firstPcA, 32'hC);
`ifdef FETCH_PERF_CNT_EN
      checkOutput("redir.perf_flush", perfFlushA, 32'd2);
`endif

      $display("[TB] END_ADDR=32 wrap boundary");
      readyB = 1; startB = 1; fromB = 0; lenB = streamLen(0, END_B); idxB = 0; tick();
      startB = 0; redirB = 1; redirAddrB = 32'd28; fromB = 28; lenB = streamLen(28, END_B);
      idxB = 0; watchB = 1; tick();
      redirB = 0;
      n = 0;
      while (doneSeenB == 0 && n < 20) begin tick(); n++; end
      checkOutput("wrap.done", 32'(doneSeenB), 32'h1);
      checkOutput("wrap.delivered", 32'(idxB), 32'h1);
      checkOutput("wrap.noFetch0", 32'(wrapFetchB), 32'h0);
      watchB = 0;

      $display("[TB] asynchronous reset mid-stream");
      applyStimulus(1, 0, 0, 1); startModelA(0); tick();
      applyStimulus(0, 0, 0, 1);
      repeat (4) tick();
      #3 rst = 1'b1;
      #1;
      checkOutput("arst.valid", 32'(validA), 32'h0);
      checkOutput("arst.busy", 32'(busyA), 32'h0);
      checkOutput("arst.imem_en", 32'(imemEnA), 32'h0);
      checkOutput("arst.imem_addr", imemAddrA, 32'h0);
      checkOutput("arst.data", dataA, 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      applyStimulus(1, 0, 0, 1); startModelA(0); tick();
      applyStimulus(0, 0, 0, 1);
      runUntilDone(30);
      checkOutput("arst.firstData", firstDataA, 32'h01200007);

      $display("[TB] randomized ready and redirect traffic");
      for (int iter = 0; iter < 8; iter++) begin
         applyStimulus(1, 0, 0, 1'($urandom_range(0, 1))); startModelA(0); tick();
         redirCount = 0;
         n = 0;
         while (doneSeenA == 0 && n < 300) begin
            if (busyA && redirCount < 3 && $urandom_range(0, 9) == 0) begin
               applyStimulus(0, 1, $urandom, 1'($urandom_range(0, 1)));
               redirCount++;
            end else
               applyStimulus(0, 0, 0, ($urandom_range(0, 3) != 0));
            tick();
            n++;
         end
         checkOutput("rand.done", 32'(doneSeenA), 32'h1);
         checkOutput("rand.delivered", 32'(idxA), 32'(lenA));
         applyStimulus(0, 0, 0, 1);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
